// File: rtl/mul_div_unit_if.sv
// Operand, HI/LO-write and result/status signals between the datapath and the MDU.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] WD;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;
  logic             done;

  modport master (
    output start, op, A, B, hi_we, lo_we, WD,
    input  HI, LO, busy, done
  );

  modport slave (
    input  start, op, A, B, hi_we, lo_we, WD,
    output HI, LO, busy, done
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: WIDTH shift-add or restoring-divide steps on
// unsigned magnitudes, with sign correction applied when HI/LO are written.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           CLK,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int unsigned CW = $clog2(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               negr_q, negr_d;
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_r, div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    a_neg = ~bus.op[0] & bus.A[WIDTH-1];
    b_neg = ~bus.op[0] & bus.B[WIDTH-1];
    a_abs = a_neg ? -bus.A : bus.A;
    b_abs = b_neg ? -bus.B : bus.B;

    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_r   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge  = div_r >= {1'b0, mcand_q};
    div_sub = div_r - {1'b0, mcand_q};
    div_rem = div_ge ? div_sub[WIDTH-1:0] : div_r[WIDTH-1:0];

    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    divz_d  = divz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.WD;
        if (bus.lo_we) lo_d = bus.WD;
        if (bus.start) begin
          // Multiply: low half holds the multiplier. Divide: low half holds the dividend.
          op_d    = bus.op;
          acc_d   = bus.op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
          mcand_d = bus.op[1] ? b_abs : a_abs;
          neg_d   = a_neg ^ b_neg;
          negr_d  = a_neg;
          divz_d  = bus.op[1] & (bus.B == '0);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = op_q[1] ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                        : {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
      end
      DONE: begin
        // Divide by zero leaves |A| as remainder; the dividend sign fix restores A.
        if (op_q[1]) begin
          lo_d = divz_q ? '1 : (neg_q ? -quo : quo);
          hi_d = negr_q ? -rem : rem;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      divz_q  <= divz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against a scoreboard of expected HI/LO pairs.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sbq[$];

  mul_div_unit_if #(.WIDTH(32)) bus ();
  mul_div_unit #(.WIDTH(32)) dut (.CLK(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", name, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    longint p;
    int sa, sb;
    logic [63:0] up;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin p = longint'(sa) * longint'(sb); r = p; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; r = up; end
      2'b10: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Drive start for one edge (the accept edge E0), then scramble operands.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    e.hi = eh;
    e.lo = el;
    sbq.push_back(e);
  endtask

  task automatic start_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    m = model(op, a, b);
    start_op(op, a, b, m.hi, m.lo);
  endtask

  // Returns in the done cycle, so a caller may start the next op immediately.
  task automatic wait_result(input string name, output int busy_n);
    int n;
    logic got;
    exp_t e;
    n = 0;
    got = 1'b0;
    busy_n = 0;
    while (!got && n < 100) begin
      if (bus.busy) busy_n++;
      if (bus.done) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check({name, "_done_seen"}, 64'(got), 64'd1);
    check({name, "_latency"}, 64'(cyc - acc_cyc), 64'd33);
    if (sbq.size() == 0) begin
      check({name, "_scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      check({name, "_HI"}, 64'(bus.HI), 64'(e.hi));
      check({name, "_LO"}, 64'(bus.LO), 64'(e.lo));
    end
  endtask

  initial begin
    int bn;
    int seen;
    logic [31:0] ph, pl, ra, rb;
    logic [1:0] rop;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.WD    = '0;

    // Reset and idle
    @(posedge clk);
    #1;
    check("reset_HI", 64'(bus.HI), 64'd0);
    check("reset_LO", 64'(bus.LO), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.hi_we = 1'b1;
    bus.WD    = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    check("mthi_HI", 64'(bus.HI), 64'hDEAD_BEEF);
    check("mthi_LO", 64'(bus.LO), 64'd0);

    // MULTU max x max, with busy length and single-cycle done
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_result("multu_max", bn);
    check("multu_busy_cycles", 64'(bn), 64'd33);
    check("multu_busy_in_done", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    check("multu_done_one_cycle", 64'(bus.done), 64'd0);

    start_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_result("mult_neg", bn);
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_result("div_neg", bn);
    start_op(2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
    wait_result("divu", bn);
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    wait_result("div_ovf", bn);
    start_op(2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
    wait_result("divu_by_zero", bn);
    start_op(2'b10, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    wait_result("div_by_zero_neg", bn);

    // Interference during RUN: start, MTHI, MTLO all ignored; HI/LO stay stale
    ph = bus.HI;
    pl = bus.LO;
    start_op(2'b00, 32'd1000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_F830);
    repeat (5) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.A     = 32'd3;
    bus.B     = 32'd3;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.WD    = 32'h5555_5555;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("run_stale_HI", 64'(bus.HI), 64'(ph));
    check("run_stale_LO", 64'(bus.LO), 64'(pl));
    wait_result("interfere", bn);
    @(posedge clk);
    #1;
    check("interfere_no_second_done", 64'(bus.done), 64'd0);
    check("interfere_no_second_busy", 64'(bus.busy), 64'd0);

    // MTLO on the accept edge lands now; the result overwrites it later
    bus.lo_we = 1'b1;
    bus.WD    = 32'hA5A5_A5A5;
    start_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    bus.lo_we = 1'b0;
    check("mtlo_with_start", 64'(bus.LO), 64'hA5A5_A5A5);
    wait_result("divu_after_mtlo", bn);

    // Back-to-back chain of random ops, each started in the previous done cycle
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'($urandom_range(1, 9)) : $urandom;
      start_model(rop, ra, rb);
      wait_result($sformatf("b2b_%0d", i), bn);
    end

    // Reset at iteration 10 aborts the op
    start_op(2'b01, 32'h1357_9BDF, 32'h2468_ACE0, 32'h0, 32'h0);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    check("abort_HI", 64'(bus.HI), 64'd0);
    check("abort_LO", 64'(bus.LO), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    start_model(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_result("after_abort", bn);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
